// File: rtl/reg_writeback_if.sv
// Bundle of the writeback block's data-path signals: the ALU result feed,
// the load-result handshake, the load-issue notification, the scoreboard
// query pair and the register-file write port.
interface reg_writeback_if;

    // ALU result feed; it has no backpressure
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;

    // Load-result handshake; a transfer happens when ld_valid & ld_ready
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;

    // Decode marks the destination of an issued load as pending
    logic        issue_valid;
    logic [4:0]  issue_rd;

    // Scoreboard queries used by decode to detect hazards
    logic [4:0]  q_rs1;
    logic [4:0]  q_rs2;
    logic        q_busy1;
    logic        q_busy2;

    // Register-file write port
    logic [4:0]  wb_rd;
    logic [31:0] wb_din;
    logic        wb_rw;
    logic        wb_enable;

    // Producer and consumer side: ALU, load unit, decode and regfile
    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_valid, ld_rd, ld_data,
        input  ld_ready,
        output issue_valid, issue_rd,
        output q_rs1, q_rs2,
        input  q_busy1, q_busy2,
        input  wb_rd, wb_din, wb_rw, wb_enable
    );

    // The writeback block itself
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_valid, ld_rd, ld_data,
        output ld_ready,
        input  issue_valid, issue_rd,
        input  q_rs1, q_rs2,
        output q_busy1, q_busy2,
        output wb_rd, wb_din, wb_rw, wb_enable
    );

endinterface

// File: rtl/reg_writeback.sv
// Register-file writer. The ALU result always wins the single write port.
// Load results are buffered in a small FIFO and drained whenever the ALU
// leaves the port free. A pending-load scoreboard is kept so that decode can
// stall on RAW/WAW hazards against loads still in flight.
module reg_writeback #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic           clk,
    input  logic           reset,
    reg_writeback_if.slave bus
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    // FIFO storage and bookkeeping
    logic [4:0]  fifo_rd_q   [DEPTH];
    logic [4:0]  fifo_rd_d   [DEPTH];
    logic [31:0] fifo_data_q [DEPTH];
    logic [31:0] fifo_data_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;

    // Scoreboard
    logic [31:0] pending_q, pending_d;

    // Registered write port
    logic [4:0]  wb_rd_q,  wb_rd_d;
    logic [31:0] wb_din_q, wb_din_d;
    logic        wb_rw_q,  wb_rw_d;

    // Per-cycle decisions
    logic        alu_take;
    logic        fifo_empty;
    logic        ld_ready;
    logic        push;
    logic        pop;
    logic [4:0]  head_rd;
    logic [31:0] head_data;

    // ld_ready depends only on the registered count, so a full FIFO refuses
    // a load even in a cycle where it is popping.
    assign ld_ready      = (count_q != FULL_COUNT);
    assign bus.ld_ready  = ld_ready;
    assign bus.q_busy1   = pending_q[bus.q_rs1];
    assign bus.q_busy2   = pending_q[bus.q_rs2];
    assign bus.wb_rd     = wb_rd_q;
    assign bus.wb_din    = wb_din_q;
    assign bus.wb_rw     = wb_rw_q;
    assign bus.wb_enable = wb_rw_q;

    assign head_rd   = fifo_rd_q[rd_ptr_q];
    assign head_data = fifo_data_q[rd_ptr_q];

    // Port arbitration: a real ALU write pre-empts the FIFO; an ALU write to
    // x0 is dropped and leaves the port free for the FIFO head.
    always_comb begin
        alu_take   = bus.alu_valid && (bus.alu_rd != '0);
        fifo_empty = (count_q == '0);
        pop        = !alu_take && !fifo_empty;
        // Loads to x0 complete the handshake but are never buffered.
        push       = bus.ld_valid && ld_ready && (bus.ld_rd != '0);
    end

    // FIFO next state: write at the tail, advance pointers, track occupancy
    always_comb begin
        fifo_rd_d   = fifo_rd_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (push) begin
            fifo_rd_d[wr_ptr_q]   = bus.ld_rd;
            fifo_data_d[wr_ptr_q] = bus.ld_data;
            wr_ptr_d              = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Write-port next state; address and data hold when nothing is written
    always_comb begin
        wb_rd_d  = wb_rd_q;
        wb_din_d = wb_din_q;
        wb_rw_d  = 1'b0;
        if (alu_take) begin
            wb_rd_d  = bus.alu_rd;
            wb_din_d = bus.alu_data;
            wb_rw_d  = 1'b1;
        end else if (pop) begin
            wb_rd_d  = head_rd;
            wb_din_d = head_data;
            wb_rw_d  = 1'b1;
        end
    end

    // Scoreboard next state: clear applied before set so a same-edge issue
    // to the register being popped keeps it pending.
    always_comb begin
        pending_d = pending_q;
        if (pop) begin
            pending_d[head_rd] = 1'b0;
        end
        if (bus.issue_valid && (bus.issue_rd != '0)) begin
            pending_d[bus.issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // State registers; FIFO contents need no reset since pointers and count do
    always_ff @(posedge clk) begin
        fifo_rd_q   <= fifo_rd_d;
        fifo_data_q <= fifo_data_d;
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pending_q <= '0;
            wb_rd_q   <= '0;
            wb_din_q  <= '0;
            wb_rw_q   <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            wb_rd_q   <= wb_rd_d;
            wb_din_q  <= wb_din_d;
            wb_rw_q   <= wb_rw_d;
        end
    end

endmodule

// File: tb/tb_reg_writeback.sv
// Testbench for reg_writeback: directed vectors, expected register-file
// writes pushed into a scoreboard queue and checked by a negedge monitor.
module tb_reg_writeback;

    logic clk = 1'b0;
    logic reset;

    reg_writeback_if bus ();

    reg_writeback #(.DEPTH(4), .AW(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [36:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wb(input logic [4:0] rd, input logic [31:0] din);
        exp_q.push_back({rd, din});
    endtask

    task automatic wait_drain(input int unsigned budget);
        for (int unsigned i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: every write on the regfile port must match the next expected one
    always @(negedge clk) begin
        if (bus.wb_rw === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got rd=%0d din=0x%08h expected no write",
                         bus.wb_rd, bus.wb_din);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                check("wb_rd_din", {27'd0, bus.wb_rd} ^ 32'(bus.wb_din != e[31:0]) << 8,
                      {27'd0, e[36:32]});
                check("wb_din", bus.wb_din, e[31:0]);
                check("wb_enable", 32'(bus.wb_enable), 32'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned li;
        logic        acc;

        reset           = 1'b1;
        bus.alu_valid   = 1'b0;
        bus.alu_rd      = '0;
        bus.alu_data    = '0;
        bus.ld_valid    = 1'b0;
        bus.ld_rd       = '0;
        bus.ld_data     = '0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
        bus.q_rs1       = '0;
        bus.q_rs2       = '0;

        // 1: reset state, then a single ALU write
        step();
        step();
        reset = 1'b0;
        check("rst_wb_rw", 32'(bus.wb_rw), 32'd0);
        check("rst_wb_en", 32'(bus.wb_enable), 32'd0);
        check("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
        check("rst_wb_din", bus.wb_din, 32'd0);
        check("rst_ld_ready", 32'(bus.ld_ready), 32'd1);

        expect_wb(5'd5, 32'hDEADBEEF);
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd5;
        bus.alu_data  = 32'hDEADBEEF;
        step();
        bus.alu_valid = 1'b0;
        check("alu_lat_rw", 32'(bus.wb_rw), 32'd1);
        check("alu_lat_rd", 32'(bus.wb_rd), 32'd5);
        step();
        check("alu_after_rw", 32'(bus.wb_rw), 32'd0);
        check("alu_hold_rd", 32'(bus.wb_rd), 32'd5);
        check("alu_hold_din", bus.wb_din, 32'hDEADBEEF);

        // 2: issued load is busy until its write, latency 2 after accept
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd7;
        bus.q_rs1       = 5'd7;
        step();
        bus.issue_valid = 1'b0;
        check("busy7_issued", 32'(bus.q_busy1), 32'd1);
        expect_wb(5'd7, 32'h1234);
        bus.ld_valid = 1'b1;
        bus.ld_rd    = 5'd7;
        bus.ld_data  = 32'h1234;
        check("ld_ready_empty", 32'(bus.ld_ready), 32'd1);
        step();
        bus.ld_valid = 1'b0;
        check("busy7_buffered", 32'(bus.q_busy1), 32'd1);
        check("ld_not_yet", 32'(bus.wb_rw), 32'd0);
        step();
        check("ld_wr_rw", 32'(bus.wb_rw), 32'd1);
        check("ld_wr_rd", 32'(bus.wb_rd), 32'd7);
        check("ld_wr_din", bus.wb_din, 32'h1234);
        check("busy7_cleared", 32'(bus.q_busy1), 32'd0);
        wait_drain(4);

        // 3: ALU starves the FIFO; it fills, then drains in order
        for (int i = 0; i < 6; i++) expect_wb(5'(i + 1), 32'h100 + 32'(i));
        for (int i = 0; i < 5; i++) expect_wb(5'(i + 8), 32'h800 + 32'(i));
        li = 0;
        for (int i = 0; i < 6; i++) begin
            bus.alu_valid = 1'b1;
            bus.alu_rd    = 5'(i + 1);
            bus.alu_data  = 32'h100 + 32'(i);
            bus.ld_valid  = (li < 5);
            bus.ld_rd     = 5'(li + 8);
            bus.ld_data   = 32'h800 + 32'(li);
            acc = bus.ld_valid && bus.ld_ready;
            step();
            if (acc) li++;
        end
        bus.alu_valid = 1'b0;
        check("full_ready", 32'(bus.ld_ready), 32'd0);
        check("full_accepted", 32'(li), 32'd4);
        for (int i = 0; i < 10; i++) begin
            if (li == 5) break;
            bus.ld_valid = 1'b1;
            bus.ld_rd    = 5'(li + 8);
            bus.ld_data  = 32'h800 + 32'(li);
            acc = bus.ld_ready;
            step();
            if (acc) li++;
        end
        bus.ld_valid = 1'b0;
        check("all_accepted", 32'(li), 32'd5);
        wait_drain(20);

        // 4: ALU to x0 does not block the FIFO; loads/issues to x0 vanish
        expect_wb(5'd1, 32'h111);
        expect_wb(5'd9, 32'h999);
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd1;
        bus.alu_data  = 32'h111;
        bus.ld_valid  = 1'b1;
        bus.ld_rd     = 5'd9;
        bus.ld_data   = 32'h999;
        step();
        bus.alu_rd    = 5'd0;
        bus.alu_data  = 32'hBAD0;
        bus.ld_rd     = 5'd0;
        bus.ld_data   = 32'hBAD1;
        check("x0_ld_ready", 32'(bus.ld_ready), 32'd1);
        step();
        check("x0_alu_pass_rw", 32'(bus.wb_rw), 32'd1);
        check("x0_alu_pass_rd", 32'(bus.wb_rd), 32'd9);
        bus.alu_valid   = 1'b0;
        bus.ld_valid    = 1'b0;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd0;
        bus.q_rs2       = 5'd0;
        step();
        bus.issue_valid = 1'b0;
        check("x0_ld_dropped", 32'(bus.wb_rw), 32'd0);
        check("x0_busy", 32'(bus.q_busy2), 32'd0);
        wait_drain(4);

        // 5: pop and issue of the same rd on one edge -> stays pending
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd3;
        step();
        bus.issue_valid = 1'b0;
        expect_wb(5'd3, 32'h333);
        bus.ld_valid = 1'b1;
        bus.ld_rd    = 5'd3;
        bus.ld_data  = 32'h333;
        step();
        bus.ld_valid    = 1'b0;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd3;
        bus.q_rs1       = 5'd3;
        step();
        bus.issue_valid = 1'b0;
        check("same_edge_wr_rd", 32'(bus.wb_rd), 32'd3);
        check("same_edge_busy3", 32'(bus.q_busy1), 32'd1);
        wait_drain(4);

        // 6: reset with buffered loads and pending bits discards everything
        for (int i = 0; i < 3; i++) begin
            bus.issue_valid = 1'b1;
            bus.issue_rd    = 5'(20 + i);
            step();
        end
        bus.issue_valid = 1'b0;
        for (int i = 0; i < 3; i++) expect_wb(5'(i + 1), 32'h6000 + 32'(i));
        for (int i = 0; i < 3; i++) begin
            bus.alu_valid = 1'b1;
            bus.alu_rd    = 5'(i + 1);
            bus.alu_data  = 32'h6000 + 32'(i);
            bus.ld_valid  = 1'b1;
            bus.ld_rd     = 5'(20 + i);
            bus.ld_data   = 32'h7000 + 32'(i);
            step();
        end
        bus.alu_valid = 1'b0;
        bus.ld_valid  = 1'b0;
        bus.q_rs1     = 5'd20;
        bus.q_rs2     = 5'd22;
        #1;
        check("pre_rst_busy20", 32'(bus.q_busy1), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_wb_rw", 32'(bus.wb_rw), 32'd0);
        check("mid_rst_ld_ready", 32'(bus.ld_ready), 32'd1);
        check("mid_rst_busy20", 32'(bus.q_busy1), 32'd0);
        check("mid_rst_busy22", 32'(bus.q_busy2), 32'd0);
        bus.q_rs1 = 5'd21;
        bus.q_rs2 = 5'd3;
        #1;
        check("mid_rst_busy21", 32'(bus.q_busy1), 32'd0);
        check("mid_rst_busy3", 32'(bus.q_busy2), 32'd0);
        for (int i = 0; i < 12; i++) step();
        check("final_queue", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
